// File: rtl/frame_pkg.sv
// Shared frame geometry, pixel/address types and the copy engine state encoding.
package frame_pkg;

   localparam int FRAME_W      = 320;
   localparam int FRAME_H      = 240;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int ADDR_W       = 17;
   localparam int PIX_W        = 8;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } copy_state_t;

endpackage

// File: rtl/frame_copy_engine_rd_latency_pipe.sv
// RD_LAT-deep {valid, addr} shift register tracking reads in flight to the source RAM.
module rd_latency_pipe #(
   parameter int RD_LAT = 2,
   parameter int ADDR_W = frame_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              busy_o
);

   logic [RD_LAT-1:0] valid_q;
   logic [ADDR_W-1:0] addr_q [RD_LAT];

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         addr_q[0]  <= addr_i;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   // The tail lines up with the source RAM returning data for that address.
   assign valid_o = valid_q[RD_LAT-1];
   assign addr_o  = addr_q[RD_LAT-1];
   assign busy_o  = |valid_q;

endmodule

// File: rtl/frame_copy_engine.sv
// Pipelined source-to-display frame copy, one pixel per clock after the read latency.
// Optional FRAME_COPY_FILL_EN adds fill_mode/fill_color to paint a constant colour instead.
module frame_copy_engine #(
   parameter int ADDR_W = frame_pkg::ADDR_W,
   parameter int DATA_W = frame_pkg::PIX_W,
   parameter int PIXELS = frame_pkg::FRAME_PIXELS,
   parameter int RD_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] src_rd_addr,
   input  logic [DATA_W-1:0] src_rd_data,
   output logic [ADDR_W-1:0] dst_wr_addr,
   output logic [DATA_W-1:0] dst_wr_data,
   output logic              dst_wren
`ifdef FRAME_COPY_FILL_EN
   ,
   input  logic              fill_mode,
   input  logic [DATA_W-1:0] fill_color
`endif
);

   import frame_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   copy_state_t       state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              pipe_valid_in;
   logic              tail_valid;
   logic [ADDR_W-1:0] tail_addr;
   logic              pipe_busy;
   logic              wren_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [DATA_W-1:0] wr_data_src;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   // Terminal detection is an equality compare, so the address never wraps mid-copy.
   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      pipe_valid_in = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               rd_addr_d = '0;
            end
         end
         RUN: begin
            pipe_valid_in = 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!pipe_busy) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d   = IDLE;
            rd_addr_d = '0;
         end
         default: begin
            state_d   = IDLE;
            rd_addr_d = '0;
         end
      endcase
   end

   rd_latency_pipe #(
      .RD_LAT (RD_LAT),
      .ADDR_W (ADDR_W)
   ) u_rd_latency_pipe (
      .clock   (clock),
      .reset   (reset),
      .valid_i (pipe_valid_in),
      .addr_i  (rd_addr_q),
      .valid_o (tail_valid),
      .addr_o  (tail_addr),
      .busy_o  (pipe_busy)
   );

`ifdef FRAME_COPY_FILL_EN
   logic              fill_mode_q;
   logic [DATA_W-1:0] fill_color_q;

   // Fill settings are frozen when a copy is accepted so mid-copy changes are ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         fill_mode_q  <= 1'b0;
         fill_color_q <= '0;
      end else if (state_q == IDLE && start) begin
         fill_mode_q  <= fill_mode;
         fill_color_q <= fill_color;
      end
   end

   assign wr_data_src = fill_mode_q ? fill_color_q : src_rd_data;
`else
   assign wr_data_src = src_rd_data;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         wren_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wren_q <= tail_valid;
         if (tail_valid) begin
            wr_addr_q <= tail_addr;
            wr_data_q <= wr_data_src;
         end
      end
   end

   assign busy        = (state_q == RUN) || (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign src_rd_addr = rd_addr_q;
   assign dst_wr_addr = wr_addr_q;
   assign dst_wr_data = wr_data_q;
   assign dst_wren    = wren_q;

endmodule

// File: tb/tb_frame_copy_engine.sv
// Scoreboard bench for frame_copy_engine on a reduced frame; define FRAME_COPY_FILL_EN to exercise fill mode.
module tb_frame_copy_engine;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;
   localparam int PIXELS = 48;
   localparam int RD_LAT = 2;
   localparam int MW     = $clog2(PIXELS);

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] src_rd_addr;
   logic [DATA_W-1:0] src_rd_data;
   logic [ADDR_W-1:0] dst_wr_addr;
   logic [DATA_W-1:0] dst_wr_data;
   logic              dst_wren;
   logic              fillMode;
   logic [DATA_W-1:0] fillColor;

   frame_copy_engine #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PIXELS (PIXELS),
      .RD_LAT (RD_LAT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .src_rd_addr (src_rd_addr),
      .src_rd_data (src_rd_data),
      .dst_wr_addr (dst_wr_addr),
      .dst_wr_data (dst_wr_data),
      .dst_wren    (dst_wren)
`ifdef FRAME_COPY_FILL_EN
      ,
      .fill_mode   (fillMode),
      .fill_color  (fillColor)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   wr_t  expQ[$];
   int   doneQ[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   busyLo = 1;
   int   busyHi = 0;
   int   freeAt = 0;
   bit   monOn = 1'b0;
   logic [DATA_W-1:0] mem    [PIXELS];
   logic [DATA_W-1:0] rdPipe [RD_LAT];

   always @(posedge clock) cyc <= cyc + 1;

   // Source RAM model: data for an address appears RD_LAT cycles after it is presented.
   always @(posedge clock) begin
      rdPipe[0] <= (int'(src_rd_addr) < PIXELS) ? mem[src_rd_addr[MW-1:0]] : '0;
      for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
   end
   assign src_rd_data = rdPipe[RD_LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic gotoCycle(input int n);
      while (cyc < n) step();
   endtask

   task automatic randomizeMem();
      for (int i = 0; i < PIXELS; i++) mem[i] = DATA_W'($urandom);
   endtask

   // Reset at cycle r cancels everything the model scheduled after r.
   task automatic purgeAfter(input int r);
      wr_t keepW[$];
      int  keepD[$];
      foreach (expQ[i]) if (expQ[i].cyc <= r) keepW.push_back(expQ[i]);
      foreach (doneQ[i]) if (doneQ[i] <= r) keepD.push_back(doneQ[i]);
      expQ  = keepW;
      doneQ = keepD;
      if (busyHi > r) busyHi = r;
      freeAt = r + 1;
   endtask

   // Drives one cycle of inputs and records what a copy started now must produce.
   task automatic applyStimulus(input bit doStart, input bit doReset, input bit fm, input logic [DATA_W-1:0] fc);
      int  t;
      bit  useFill;
      wr_t e;
      t = cyc;
`ifdef FRAME_COPY_FILL_EN
      useFill = fm;
`else
      useFill = 1'b0;
`endif
      start     = doStart;
      reset     = doReset;
      fillMode  = fm;
      fillColor = fc;
      if (doReset) begin
         purgeAfter(t);
      end else if (doStart && t >= freeAt) begin
         for (int a = 0; a < PIXELS; a++) begin
            e.cyc  = t + RD_LAT + 2 + a;
            e.addr = a;
            e.data = useFill ? int'(fc) : int'(mem[a]);
            expQ.push_back(e);
         end
         doneQ.push_back(t + PIXELS + RD_LAT + 2);
         busyLo = t + 1;
         busyHi = t + PIXELS + RD_LAT + 1;
         freeAt = t + PIXELS + RD_LAT + 3;
      end
      step();
      start = 1'b0;
      reset = 1'b0;
   endtask

   always @(negedge clock) begin
      wr_t e;
      if (monOn) begin
         while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            checkOutput("write_issued", 32'd0, 32'd1);
         end
         while (doneQ.size() > 0 && doneQ[0] < cyc) begin
            void'(doneQ.pop_front());
            checkOutput("done_issued", 32'd0, 32'd1);
         end
         if (dst_wren) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("write_cycle", cyc, e.cyc);
               checkOutput("write_addr", 32'(dst_wr_addr), e.addr);
               checkOutput("write_data", 32'(dst_wr_data), e.data);
            end
         end
         if (done) begin
            if (doneQ.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
            else checkOutput("done_cycle", cyc, doneQ.pop_front());
         end
         checkOutput("busy", 32'(busy), 32'((cyc >= busyLo) && (cyc <= busyHi)));
         checkOutput("done_and_wren", 32'(done & dst_wren), 32'd0);
      end
   end

   initial begin
      int t;
      reset     = 1'b1;
      start     = 1'b0;
      fillMode  = 1'b0;
      fillColor = '0;
      randomizeMem();
      repeat (3) step();
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_src_rd_addr", 32'(src_rd_addr), 32'd0);
      checkOutput("reset_dst_wr_addr", 32'(dst_wr_addr), 32'd0);
      checkOutput("reset_dst_wr_data", 32'(dst_wr_data), 32'd0);
      checkOutput("reset_dst_wren", 32'(dst_wren), 32'd0);
      reset  = 1'b0;
      freeAt = cyc;
      monOn  = 1'b1;
      step();

      $display("[TB] plain copy");
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(freeAt + 2);

      $display("[TB] start while busy and while done");
      randomizeMem();
      t = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(t + 10);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(t + PIXELS + RD_LAT + 2);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(freeAt + 3);

      $display("[TB] back-to-back copies");
      randomizeMem();
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(freeAt);
      randomizeMem();
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      gotoCycle(freeAt + 1);

      $display("[TB] reset mid-copy");
      for (int k = 0; k < 3; k++) begin
         randomizeMem();
         t = cyc;
         applyStimulus(1'b1, 1'b0, 1'b0, '0);
         gotoCycle(t + 1 + int'($urandom_range(0, PIXELS + RD_LAT + 1)));
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         randomizeMem();
         applyStimulus(1'b1, 1'b0, 1'b0, '0);
         gotoCycle(freeAt + 1);
      end

      $display("[TB] start with reset");
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      repeat (PIXELS / 4) step();

      $display("[TB] fill colour");
      randomizeMem();
      applyStimulus(1'b1, 1'b0, 1'b1, 8'hE0);
      gotoCycle(freeAt + 1);

      $display("[TB] random copies");
      for (int k = 0; k < 6; k++) begin
         randomizeMem();
         repeat ($urandom_range(0, 3)) step();
         t = cyc;
         applyStimulus(1'b1, 1'b0, 1'($urandom), DATA_W'($urandom));
         gotoCycle(t + 1 + int'($urandom_range(1, PIXELS)));
         applyStimulus(1'($urandom), 1'b0, 1'($urandom), DATA_W'($urandom));
         gotoCycle(freeAt);
      end

      gotoCycle(freeAt + 5);
      checkOutput("pending_writes", expQ.size(), 32'd0);
      checkOutput("pending_done", doneQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_copy_engine.md
Name: frame_copy_engine

Overview:
- Streaming copy stage downstream of the zoom algorithm's working memory.
- Reads every pixel of the 320x240 working frame from the source RAM and writes it to the display RAM at the same address. The VGA reader then shows the new image.
- Fully pipelined: one pixel per clock after a fixed read latency. Replaces the per-pixel multi-cycle read/write ping-pong.
- Controlled by the top-level FSM through a start/busy/done handshake.

Parameters:
- ADDR_W, 17, address width of source and destination RAMs.
- DATA_W, 8, pixel width (RGB332).
- PIXELS, 76800, number of pixels copied (320*240); last address is PIXELS-1.
- RD_LAT, 2, source RAM read latency in cycles from address presented to data valid; legal range 1..4.

Ports:
- clock  in  1  system clock (clk_100 domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a copy; sampled only in IDLE.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle pulse when the final write has been issued.
- src_rd_addr  out  ADDR_W  source RAM read address (registered).
- src_rd_data  in  DATA_W  source RAM read data, valid RD_LAT cycles after its address.
- dst_wr_addr  out  ADDR_W  destination RAM write address (registered).
- dst_wr_data  out  DATA_W  destination RAM write data (registered).
- dst_wren  out  1  destination RAM write enable (registered).
- fill_mode  in  1  present only with FRAME_COPY_FILL_EN; see Optional Feature.
- fill_color  in  DATA_W  present only with FRAME_COPY_FILL_EN.

Behaviour:
- Reset: every output is 0 (busy, done, src_rd_addr, dst_wr_addr, dst_wr_data, dst_wren). State is IDLE and the valid pipeline is cleared.
- Reset mid-copy: aborts the copy. dst_wren is 0 from the cycle after reset is sampled, no done pulse is generated, and destination contents are left partially updated.
- IDLE:
  - start=1 sampled at cycle T -> state RUN, busy=1 and src_rd_addr=0 at T+1.
  - start=0 -> remain in IDLE.
- RUN:
  - One new address per cycle; src_rd_addr increments by 1 each cycle.
  - Each address enters an RD_LAT-deep shift register carrying {valid, addr}.
  - Once src_rd_addr=PIXELS-1 has been presented, go to DRAIN. The read address holds at PIXELS-1 and no new valid entries are inserted.
- DRAIN: continues until the pipeline is empty, then moves to DONE.
- Write path:
  - In the cycle the shift-register tail is valid for address a, src_rd_data is captured.
  - The next cycle drives dst_wren=1, dst_wr_addr=a, dst_wr_data=captured value.
  - A read presented at cycle t produces its write at t+RD_LAT+1.
- DONE:
  - One cycle long: done=1, busy=0, dst_wren=0.
  - Next state is IDLE; src_rd_addr returns to 0.
- Latency with start at T:
  - First write at T+RD_LAT+2.
  - Last write at T+PIXELS+RD_LAT+1.
  - done at T+PIXELS+RD_LAT+2.
  - Exactly PIXELS writes, each address written once, in ascending order, with no gaps.
- start while busy or in DONE: ignored. No queuing, no restart.
- start together with reset: reset wins.
- Counter arithmetic: ADDR_W unsigned. Terminal detection uses equality with PIXELS-1, so there is never a wrap to 0 mid-copy.
- done and dst_wren are never high in the same cycle.

Optional Feature:
- Macro FRAME_COPY_FILL_EN.
- With the macro:
  - fill_mode and fill_color ports exist and are sampled at start acceptance.
  - If fill_mode=1, every write uses the latched fill_color instead of src_rd_data. This clears or paints the display frame.
  - Timing, address sequence and done are identical to a normal copy.
- Without the macro: the ports are absent and every write always carries src_rd_data.

Decomposition:
- Shared package frame_pkg:
  - FRAME_W=320, FRAME_H=240, FRAME_PIXELS=76800.
  - ADDR_W=17, PIX_W=8.
  - Typedef pix_t, typedef addr_t.
  - State enum copy_state_t {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module, rd_latency_pipe: the parameterised RD_LAT-stage {valid, addr} shift register with synchronous clear.

Test Plan:
- Source model with RD_LAT=2 and mem[a]=a[7:0]; start at T -> first dst_wren at T+4 with addr 0 / data 0x00; done at T+76804; destination equals source over all 76800 addresses; exactly 76800 writes.
- PIXELS=16, RD_LAT=1, start -> writes to addresses 0..15 on consecutive cycles with data mem[0..15], done 1 cycle after the last write, busy low from done onward.
- start pulsed again at T+100 during the copy -> ignored; write count stays 76800 and exactly one done pulse.
- reset asserted at T+500 -> dst_wren=0 and busy=0 at T+501, no done pulse; a new start then copies the full frame correctly from address 0.
- PIXELS=16, RD_LAT=4, back-to-back start on the cycle after done -> second copy begins normally; total 32 writes and 2 done pulses.
- With FRAME_COPY_FILL_EN, fill_mode=1, fill_color=8'hE0 -> all 76800 writes carry 0xE0, with timing identical to the copy case; with fill_mode=0 the result equals a normal copy.
